// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC datapath.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int DATA_FRAC_DEF  = 15;
  localparam int PROD_WIDTH     = 2 * DATA_WIDTH_DEF;
  localparam int PROD_FRAC      = 2 * DATA_FRAC_DEF;

  // Clip a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file; writes are dropped while the MAC loop is reading it.
module fir_coef_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int NTAPS      = 8,
  parameter int ADDR_WIDTH = $clog2(NTAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic                         busy,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  logic signed [DATA_WIDTH-1:0] mem [NTAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (we && !busy) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fmult.sv
// Signed fixed-point multiplier: rescales the full product to DOUT_FRAC and saturates to DOUT_WIDTH.
module fmult
  import fir_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_FRAC   = 15,
  parameter int DOUT_WIDTH = 32,
  parameter int DOUT_FRAC  = 30
) (
  input  logic signed [DIN_WIDTH-1:0]  i_a,
  input  logic signed [DIN_WIDTH-1:0]  i_b,
  output logic signed [DOUT_WIDTH-1:0] o_dout,
  output logic                         o_ovr
);

  localparam int SH = 2 * DIN_FRAC - DOUT_FRAC;

  logic signed [2*DIN_WIDTH-1:0] prod;
  logic signed [63:0]            scaled;
  logic signed [63:0]            clipped;

  assign prod    = (2*DIN_WIDTH)'(i_a) * (2*DIN_WIDTH)'(i_b);
  assign scaled  = 64'(prod) >>> SH;
  assign clipped = sat_clip(scaled, DOUT_WIDTH);
  assign o_dout  = clipped[DOUT_WIDTH-1:0];
  assign o_ovr   = (clipped != scaled);

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR filter sharing one fmult across NTAPS taps, one tap per cycle, Q1.15 in/out.
// Define FIR_MAC_PIPE_EN to register the multiplier output (one extra MAC cycle).
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DATA_FRAC  = DATA_FRAC_DEF,
  parameter int NTAPS      = 8,
  parameter int GUARD_BITS = $clog2(NTAPS) + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  input  logic signed [DATA_WIDTH-1:0] i_in_data,
  output logic                         o_in_ready,
  input  logic                         i_coef_we,
  input  logic [$clog2(NTAPS)-1:0]     i_coef_addr,
  input  logic signed [DATA_WIDTH-1:0] i_coef_data,
  output logic                         o_busy,
  output logic                         o_out_valid,
  output logic signed [DATA_WIDTH-1:0] o_out_data,
  output logic                         o_out_ovr,
  input  logic                         i_out_ready
);

  localparam int TW    = $clog2(NTAPS);
  // Product format scales with the data format: Q2.30 at the default Q1.15.
  localparam int PW    = PROD_WIDTH / DATA_WIDTH_DEF * DATA_WIDTH;
  localparam int PF    = PROD_FRAC / DATA_FRAC_DEF * DATA_FRAC;
  localparam int ACC_W = PW + GUARD_BITS;
`ifdef FIR_MAC_PIPE_EN
  localparam int LAST = NTAPS;
`else
  localparam int LAST = NTAPS - 1;
`endif
  localparam logic [TW:0] LAST_CNT = (TW+1)'(LAST);

  state_t                       state_q, state_d;
  logic [TW-1:0]                wptr, base, rd_idx;
  logic [TW:0]                  cnt;
  logic signed [DATA_WIDTH-1:0] line [NTAPS];
  logic signed [ACC_W-1:0]      acc, acc_nxt, add_term;
  logic                         ovr, ovr_nxt, add_ovr, add_en;
  logic signed [DATA_WIDTH-1:0] coef_rd, samp_rd;
  logic signed [PW-1:0]         prod_p0;
  logic                         povr_p0;
  logic                         accept, last_tap;
  logic signed [63:0]           y_wide, y_clip;
  logic signed [DATA_WIDTH-1:0] y_p0;
  logic                         y_sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_in_ready  = 1'b0;
    o_busy      = 1'b0;
    o_out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) state_d = MAC;
      end
      MAC: begin
        o_busy = 1'b1;
        if (last_tap) state_d = DONE;
      end
      DONE: begin
        o_out_valid = 1'b1;
        o_in_ready  = i_out_ready;
        if (i_out_ready) state_d = i_in_valid ? MAC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = i_in_valid && o_in_ready;
  assign last_tap = (cnt == LAST_CNT);
  assign rd_idx   = base - cnt[TW-1:0];
  assign samp_rd  = line[rd_idx];

  fir_coef_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NTAPS      (NTAPS)
  ) u_coef_bank (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (i_coef_we),
    .waddr (i_coef_addr),
    .wdata (i_coef_data),
    .busy  (o_busy),
    .raddr (cnt[TW-1:0]),
    .rdata (coef_rd)
  );

  fmult #(
    .DIN_WIDTH  (DATA_WIDTH),
    .DIN_FRAC   (DATA_FRAC),
    .DOUT_WIDTH (PW),
    .DOUT_FRAC  (PF)
  ) u_fmult (
    .i_a    (coef_rd),
    .i_b    (samp_rd),
    .o_dout (prod_p0),
    .o_ovr  (povr_p0)
  );

`ifdef FIR_MAC_PIPE_EN
  // p0 -> p1: product register; vld_p1 marks a product that belongs to a real tap
  logic signed [PW-1:0] prod_p1;
  logic                 povr_p1;
  logic                 vld_p1;

  always_ff @(posedge i_clk) begin
    prod_p1 <= prod_p0;
    povr_p1 <= povr_p0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_p1 <= 1'b0;
    else          vld_p1 <= o_busy && !last_tap;
  end

  assign add_en   = vld_p1;
  assign add_term = ACC_W'(prod_p1);
  assign add_ovr  = povr_p1;
`else
  assign add_en   = 1'b1;
  assign add_term = ACC_W'(prod_p0);
  assign add_ovr  = povr_p0;
`endif

  assign acc_nxt = acc + (add_en ? add_term : {ACC_W{1'b0}});
  assign ovr_nxt = ovr | (add_en & add_ovr);

  // Arithmetic shift floors toward -inf before clipping to the output range.
  assign y_wide = 64'(acc_nxt) >>> DATA_FRAC;
  assign y_clip = sat_clip(y_wide, DATA_WIDTH);
  assign y_p0   = y_clip[DATA_WIDTH-1:0];
  assign y_sat  = (y_clip != y_wide);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr       <= '0;
      base       <= '0;
      cnt        <= '0;
      acc        <= '0;
      ovr        <= 1'b0;
      o_out_data <= '0;
      o_out_ovr  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) line[i] <= '0;
    end else if (accept) begin
      line[wptr] <= i_in_data;
      base       <= wptr;
      wptr       <= wptr + TW'(1);
      acc        <= '0;
      ovr        <= 1'b0;
      cnt        <= '0;
    end else if (o_busy) begin
      acc <= acc_nxt;
      ovr <= ovr_nxt;
      cnt <= cnt + (TW+1)'(1);
      if (last_tap) begin
        o_out_data <= y_p0;
        o_out_ovr  <= ovr_nxt | y_sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed and randomized bench for fir_mac_scheduler against a sum-of-products reference.
`timescale 1ns/1ps
module tb_fir_mac_scheduler;

  localparam int NT = 8;
`ifdef FIR_MAC_PIPE_EN
  localparam int LAT = NT + 2;
`else
  localparam int LAT = NT + 1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic [15:0] i_in_data = '0;
  logic        o_in_ready;
  logic        i_coef_we = 1'b0;
  logic [2:0]  i_coef_addr = '0;
  logic [15:0] i_coef_data = '0;
  logic        o_busy;
  logic        o_out_valid;
  logic [15:0] o_out_data;
  logic        o_out_ovr;
  logic        i_out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  longint coef_m [NT];
  longint hist_m [NT];

  fir_mac_scheduler #(
    .DATA_WIDTH (16),
    .DATA_FRAC  (15),
    .NTAPS      (NT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .o_busy      (o_busy),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_out_ovr   (o_out_ovr),
    .i_out_ready (i_out_ready)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear;
    for (int k = 0; k < NT; k++) begin
      coef_m[k] = 0;
      hist_m[k] = 0;
    end
  endtask

  // hist_m[k] is x[n-k]; newest sample at index 0.
  task automatic model_push(input logic [15:0] x);
    for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = longint'($signed(x));
  endtask

  function automatic void model_y(output logic [15:0] y, output logic ovr);
    longint sum;
    longint q;
    sum = 0;
    for (int k = 0; k < NT; k++) sum += coef_m[k] * hist_m[k];
    q = sum >>> 15;
    if (q > 32767) begin
      y = 16'h7FFF; ovr = 1'b1;
    end else if (q < -32768) begin
      y = 16'h8000; ovr = 1'b1;
    end else begin
      y = q[15:0]; ovr = 1'b0;
    end
  endfunction

  function automatic logic [15:0] rnd_coef();
    return 16'($urandom_range(0, 16'h1FFF)) - 16'h1000;
  endfunction

  task automatic dut_reset;
    i_in_valid  = 1'b0;
    i_coef_we   = 1'b0;
    i_out_ready = 1'b0;
    i_rst_n     = 1'b0;
    step;
    step;
    i_rst_n = 1'b1;
    step;
    model_clear();
  endtask

  task automatic wr_coef(input logic [2:0] addr, input logic [15:0] data);
    i_coef_we   = 1'b1;
    i_coef_addr = addr;
    i_coef_data = data;
    step;
    i_coef_we = 1'b0;
    coef_m[addr] = longint'($signed(data));
  endtask

  // Called one cycle after the input handshake edge; lat counts cycles since the handshake.
  task automatic wait_out(input bit busy_wr, input logic [2:0] bwa, input logic [15:0] bwd,
                          input int hold, input bit consume, output logic [15:0] y_obs);
    int          lat;
    logic [15:0] ey;
    logic        eo;
    logic [15:0] d0;
    logic        o0;
    lat = 1;
    while (!o_out_valid && lat < 4 * LAT) begin
      if (busy_wr && lat == 3) begin
        chk1("busy_at_write", o_busy, 1'b1);
        i_coef_we   = 1'b1;
        i_coef_addr = bwa;
        i_coef_data = bwd;
      end
      step;
      i_coef_we = 1'b0;
      lat++;
    end
    chki("latency", lat, LAT);
    model_y(ey, eo);
    chk16("y", o_out_data, ey);
    chk1("ovr", o_out_ovr, eo);
    y_obs = o_out_data;
    d0    = o_out_data;
    o0    = o_out_ovr;
    for (int i = 0; i < hold; i++) begin
      step;
      chk1("hold_valid", o_out_valid, 1'b1);
      chk16("hold_y", o_out_data, d0);
      chk1("hold_ovr", o_out_ovr, o0);
      chk1("hold_in_ready", o_in_ready, 1'b0);
    end
    if (consume) begin
      i_out_ready = 1'b1;
      step;
      i_out_ready = 1'b0;
    end
  endtask

  task automatic send(input logic [15:0] x, input int hold, input bit busy_wr,
                      input logic [2:0] bwa, input logic [15:0] bwd, output logic [15:0] y_obs);
    int n;
    n = 0;
    while (!o_in_ready && n < 20) begin
      step;
      n++;
    end
    chk1("in_ready", o_in_ready, 1'b1);
    i_in_valid = 1'b1;
    i_in_data  = x;
    step;
    i_in_valid = 1'b0;
    model_push(x);
    wait_out(busy_wr, bwa, bwd, hold, 1'b1, y_obs);
  endtask

  initial begin
    logic [15:0] y;
    logic [15:0] r;
    logic [15:0] exp_y;
    longint      p;
    bit          stale;

    // Reset state
    i_rst_n = 1'b0;
    step;
    step;
    chk1("rst_in_ready", o_in_ready, 1'b1);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_out_valid", o_out_valid, 1'b0);
    chk16("rst_out_data", o_out_data, 16'h0000);
    chk1("rst_out_ovr", o_out_ovr, 1'b0);
    i_rst_n = 1'b1;
    step;
    model_clear();

    // Single sample: 0.5 * 0.25
    for (int k = 0; k < NT; k++) wr_coef(3'(k), 16'h4000);
    send(16'h2000, 0, 1'b0, 3'd0, 16'h0, y);
    chk16("single_y", y, 16'h1000);

    // Positive saturation ramp
    dut_reset();
    for (int k = 0; k < NT; k++) wr_coef(3'(k), 16'h7FFF);
    for (int i = 0; i < NT; i++) begin
      send(16'h7FFF, 0, 1'b0, 3'd0, 16'h0, y);
      if (i == 0) chk16("possat_first", y, 16'h7FFE);
    end
    chk16("possat_eighth", y, 16'h7FFF);

    // -1 x -1 corner and negative full scale
    dut_reset();
    wr_coef(3'd0, 16'h8000);
    send(16'h8000, 0, 1'b0, 3'd0, 16'h0, y);
    chk16("neg1_sq", y, 16'h7FFF);
    send(16'h7FFF, 0, 1'b0, 3'd0, 16'h0, y);
    chk16("neg_fullscale", y, 16'h8001);

    // Backpressure then back-to-back accept
    dut_reset();
    for (int k = 0; k < NT; k++) wr_coef(3'(k), rnd_coef());
    r = 16'($urandom);
    i_in_valid = 1'b1;
    i_in_data  = r;
    step;
    i_in_valid = 1'b0;
    model_push(r);
    wait_out(1'b0, 3'd0, 16'h0, 10, 1'b0, y);
    r = 16'($urandom);
    i_in_valid  = 1'b1;
    i_in_data   = r;
    i_out_ready = 1'b1;
    #1;
    chk1("b2b_in_ready", o_in_ready, 1'b1);
    step;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    model_push(r);
    chk1("b2b_busy", o_busy, 1'b1);
    chk1("b2b_valid_low", o_out_valid, 1'b0);
    wait_out(1'b0, 3'd0, 16'h0, 0, 1'b1, y);

    // Coefficient write while busy is dropped; same write in IDLE applies
    dut_reset();
    for (int k = 0; k < NT; k++) wr_coef(3'(k), (k == 3) ? 16'h0555 : rnd_coef());
    send(16'h4000, 0, 1'b1, 3'd3, 16'h1234, y);
    for (int i = 0; i < 3; i++) send(16'h0000, 0, 1'b0, 3'd0, 16'h0, y);
    chk16("busy_write_dropped", y, 16'h02AA);
    for (int i = 0; i < 4; i++) send(16'h0000, 0, 1'b0, 3'd0, 16'h0, y);
    wr_coef(3'd3, 16'h1234);
    send(16'h4000, 0, 1'b0, 3'd0, 16'h0, y);
    for (int i = 0; i < 3; i++) send(16'h0000, 0, 1'b0, 3'd0, 16'h0, y);
    chk16("idle_write_applied", y, 16'h091A);

    // Randomized stream with wrap-around, backpressure and mixed coefficient writes
    dut_reset();
    for (int k = 0; k < NT; k++) wr_coef(3'(k), rnd_coef());
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) wr_coef(3'($urandom_range(0, NT - 1)), rnd_coef());
      send(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, NT - 1)), rnd_coef(), y);
    end

    // Reset in the middle of MAC
    i_in_valid = 1'b1;
    i_in_data  = 16'($urandom);
    step;
    i_in_valid = 1'b0;
    step;
    step;
    step;
    chk1("pre_reset_busy", o_busy, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk1("midrst_busy", o_busy, 1'b0);
    chk1("midrst_valid", o_out_valid, 1'b0);
    chk1("midrst_in_ready", o_in_ready, 1'b1);
    chk16("midrst_data", o_out_data, 16'h0000);
    chk1("midrst_ovr", o_out_ovr, 1'b0);
    step;
    step;
    i_rst_n = 1'b1;
    model_clear();
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (o_out_valid) stale = 1'b1;
    end
    chk1("no_stale_output", stale, 1'b0);
    chk1("post_rst_in_ready", o_in_ready, 1'b1);
    for (int k = 0; k < NT; k++) wr_coef(3'(k), rnd_coef());
    r = 16'($urandom);
    send(r, 0, 1'b0, 3'd0, 16'h0, y);
    p = (coef_m[0] * longint'($signed(r))) >>> 15;
    exp_y = (p > 32767) ? 16'h7FFF : (p < -32768) ? 16'h8000 : p[15:0];
    chk16("post_rst_impulse", y, exp_y);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Time-multiplexes one shared fmult instance across NTAPS filter taps to compute y[n] = sum c[k]*x[n-k], k=0..NTAPS-1, in Q1.15.
- Owns the sample delay line, the coefficient register file, the wide accumulator, output saturation and the sticky overflow flag.
- Sits between the sample source and the error/update stage of the adaptive filter.
- Uses valid/ready handshakes on input and output.

Parameters:
- DATA_WIDTH, 16, width of samples, coefficients and output.
- DATA_FRAC, 15, fractional bits of samples, coefficients and output.
- NTAPS, 8, number of taps; power of two, at least 2.
- GUARD_BITS, $clog2(NTAPS)+1, accumulator guard bits above the full-precision product.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_in_valid  in  1  input sample valid.
- i_in_data  in  DATA_WIDTH  input sample x[n], signed.
- o_in_ready  out  1  input sample accepted when high together with i_in_valid.
- i_coef_we  in  1  coefficient write strobe.
- i_coef_addr  in  $clog2(NTAPS)  coefficient index k.
- i_coef_data  in  DATA_WIDTH  coefficient c[k], signed.
- o_busy  out  1  high while in MAC state.
- o_out_valid  out  1  y[n] valid.
- o_out_data  out  DATA_WIDTH  y[n], signed, saturated.
- o_out_ovr  out  1  overflow flag for this y[n].
- i_out_ready  in  1  downstream accepts y[n].

Behaviour:
- Reset (asynchronous assert, synchronous-to-i_clk release):
  - state=IDLE; o_in_ready=1; o_busy=0; o_out_valid=0; o_out_data=0; o_out_ovr=0.
  - Delay line, coefficients, accumulator and write pointer cleared to 0.
  - Reset during MAC or DONE discards the sample in flight; no output is produced.
- IDLE:
  - o_in_ready=1.
  - On i_in_valid: write x into line[wptr], latch base=wptr, wptr+=1 (wraps mod NTAPS), clear accumulator and ovr, tap=0, go to MAC.
- MAC (NTAPS cycles):
  - Each cycle the fmult operands are c[tap] and line[(base-tap) mod NTAPS].
  - fmult is configured with DOUT_WIDTH=2*DATA_WIDTH, DOUT_FRAC=2*DATA_FRAC (full precision, Q2.30 at defaults).
  - Its product is sign-extended and added into the accumulator. Accumulator width is 2*DATA_WIDTH+GUARD_BITS; it never wraps.
  - The fmult o_ovr is ORed into sticky ovr.
  - tap increments; after tap=NTAPS-1, go to DONE.
  - o_in_ready=0; o_busy=1.
- DONE:
  - o_out_valid=1.
  - o_out_data = accumulator >> DATA_FRAC, truncated toward -inf, then saturated to [-2^(DW-1), 2^(DW-1)-1].
  - o_out_ovr = ovr OR saturation occurred.
  - o_out_data and o_out_ovr are registered and stable while o_out_valid=1 and i_out_ready=0.
  - o_in_ready = i_out_ready.
  - On i_out_ready: if i_in_valid in the same cycle, accept the new sample and go straight to MAC (back-to-back, no idle cycle); otherwise go to IDLE.
- Latency: input handshake at cycle 0 gives o_out_valid at cycle NTAPS+1. Throughput is one sample per NTAPS+1 cycles.
- Coefficient writes:
  - Applied in IDLE and DONE.
  - Ignored (dropped) when o_busy=1.
  - A write in the same cycle as an input accept takes effect before the first MAC cycle.
- Wrap-around: the delay line is circular. Samples older than NTAPS-1 are overwritten. Before NTAPS samples have arrived since reset, missing history reads 0.

Optional Feature:
- Macro: FIR_MAC_PIPE_EN.
- Defined:
  - A register stage sits on the fmult product and its ovr.
  - MAC lasts NTAPS+1 cycles; the accumulator skips the first cycle and adds the registered product thereafter.
  - Latency is NTAPS+2; throughput is one sample per NTAPS+2 cycles.
- Undefined: the combinational product feeds the accumulator directly, as described in Behaviour.

Decomposition:
- Shared package fir_pkg:
  - state enum {IDLE, MAC, DONE}.
  - localparams PROD_WIDTH=2*DATA_WIDTH, PROD_FRAC=2*DATA_FRAC.
  - a saturation helper function.
- Sub-modules:
  - The existing fmult is instantiated once.
  - Sub-module fir_coef_bank: coefficient register file with write port, read port and busy write-gating.

Test Plan:
- Single sample, NTAPS=8: all c=0x4000, one x=0x2000 after reset -> y=0x1000, ovr=0, o_out_valid at cycle 9 (cycle 10 with FIR_MAC_PIPE_EN).
- Positive saturation: all c=0x7FFF, 8 samples of 0x7FFF -> eighth output 0x7FFF with ovr=1. Earlier outputs: 1st=0x7FFE ovr=0; 2nd saturates.
- -1 x -1 corner: c[0]=0x8000, others 0, x=0x8000 -> product 1.0 -> y=0x7FFF, ovr=1. Negative full-scale: c[0]=0x8000, x=0x7FFF -> y=0x8001, ovr=0.
- Backpressure and back-to-back:
  - Hold i_out_ready=0 for 10 cycles -> o_out_data and o_out_ovr stable, o_in_ready=0.
  - Raise i_out_ready with i_in_valid=1 -> new sample accepted that cycle, MAC starts next cycle.
- Coefficient write while busy: write c[3]=0x1234 during MAC -> ignored, readback via impulse response unchanged. The same write in IDLE -> applied.
- Reset mid-MAC: assert i_rst_n=0 at tap 3 -> all outputs 0 immediately. After release: o_in_ready=1, no stale output, delay line zeroed (impulse test gives y=c[0]*x only).
